// File: rtl/pe_row_conv_pkg.sv
// Shared definitions for the row-convolution PE stage: FSM state encoding and default widths.
package pe_row_conv_pkg;

   localparam int DATA_W_DEF  = 16;
   localparam int PSUM_W_DEF  = 32;
   localparam int FILT_S_DEF  = 3;
   localparam int IFMAP_W_DEF = 13;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LD_F = 3'd1,
      ST_LD_I = 3'd2,
      ST_MAC  = 3'd3,
      ST_OUT  = 3'd4
   } state_t;

endpackage

// File: rtl/pe_row_conv_mac.sv
// Signed DATA_W x DATA_W multiplier feeding a wrapping PSUM_W accumulator.
module pe_row_conv_mac
   import pe_row_conv_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int PSUM_W = PSUM_W_DEF
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [PSUM_W-1:0] acc
);

   logic signed [2*DATA_W-1:0] prod;
   logic signed [PSUM_W-1:0]   prod_ext;

   assign prod     = a * b;
   // Sign-extends (or truncates) the full-precision product to the accumulator width.
   assign prod_ext = PSUM_W'(prod);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         acc <= '0;
      end else if (en) begin
         acc <= (clr ? '0 : acc) + prod_ext;
      end
   end

endmodule

// File: rtl/pe_row_conv.sv
// 1-D row-convolution PE stage: loads FILT_S weights, slides an ifmap window, emits one psum per position.
// Optional PE_PSUM_IN_EN adds a psum input FIFO whose head is summed into every output psum.
//
// state | meaning
// IDLE  | waiting for START
// LD_F  | popping FILT_S weights from the filter FIFO
// LD_I  | shifting ifmap pixels into the window until it holds FILT_S pixels
// MAC   | FILT_S multiply-accumulate cycles over the window
// OUT   | presenting the psum, waiting for downstream room
module pe_row_conv
   import pe_row_conv_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int PSUM_W  = PSUM_W_DEF,
   parameter int FILT_S  = FILT_S_DEF,
   parameter int IFMAP_W = IFMAP_W_DEF
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     EN,
   input  logic                     START,
   input  logic signed [DATA_W-1:0] FILT_DI,
   input  logic                     FILT_EMPTY,
   output logic                     FILT_READ,
   input  logic signed [DATA_W-1:0] IF_DI,
   input  logic                     IF_EMPTY,
   output logic                     IF_READ,
`ifdef PE_PSUM_IN_EN
   input  logic signed [PSUM_W-1:0] PSIN_DI,
   input  logic                     PSIN_EMPTY,
   output logic                     PSIN_READ,
`endif
   output logic signed [PSUM_W-1:0] PSUM_DO,
   output logic                     PSUM_WRITE,
   input  logic                     PSUM_FULL,
   output logic                     BUSY,
   output logic                     DONE
);

   localparam int NOUT = IFMAP_W - FILT_S + 1;
   localparam int KW   = $clog2(FILT_S);
   localparam int FW   = $clog2(FILT_S + 1);
   localparam int OW   = $clog2(NOUT + 1);

   localparam logic [KW-1:0] K_LAST    = KW'(FILT_S - 1);
   localparam logic [FW-1:0] FILL_LAST = FW'(FILT_S - 1);
   localparam logic [OW-1:0] O_LAST    = OW'(NOUT - 1);

   state_t                   state_q, state_d;
   logic [KW-1:0]            k_q;
   logic [KW-1:0]            j_q;
   logic [FW-1:0]            fill_q;
   logic [OW-1:0]            o_q;
   logic signed [DATA_W-1:0] w_q   [FILT_S];
   logic signed [DATA_W-1:0] win_q [FILT_S];
   logic signed [PSUM_W-1:0] acc;

   logic act;
   logic out_rdy;
   logic filt_rd_c, if_rd_c, psum_wr_c, mac_c;
   logic filt_rd, if_rd, psum_wr, mac_en;

   assign act = EN && !RESET;

`ifdef PE_PSUM_IN_EN
   assign out_rdy   = !PSUM_FULL && !PSIN_EMPTY;
   assign PSIN_READ = psum_wr;
   assign PSUM_DO   = acc + PSIN_DI;
`else
   assign out_rdy   = !PSUM_FULL;
   assign PSUM_DO   = acc;
`endif

   always_comb begin
      state_d   = state_q;
      filt_rd_c = 1'b0;
      if_rd_c   = 1'b0;
      psum_wr_c = 1'b0;
      mac_c     = 1'b0;
      case (state_q)
         ST_IDLE: if (START) state_d = ST_LD_F;
         ST_LD_F: begin
            if (!FILT_EMPTY) begin
               filt_rd_c = 1'b1;
               if (k_q == K_LAST) state_d = ST_LD_I;
            end
         end
         ST_LD_I: begin
            if (!IF_EMPTY) begin
               if_rd_c = 1'b1;
               if (fill_q == FILL_LAST) state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            mac_c = 1'b1;
            if (j_q == K_LAST) state_d = ST_OUT;
         end
         ST_OUT: begin
            if (out_rdy) begin
               psum_wr_c = 1'b1;
               state_d   = (o_q == O_LAST) ? ST_IDLE : ST_LD_I;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign filt_rd = act && filt_rd_c;
   assign if_rd   = act && if_rd_c;
   assign psum_wr = act && psum_wr_c;
   assign mac_en  = act && mac_c;

   assign FILT_READ  = filt_rd;
   assign IF_READ    = if_rd;
   assign PSUM_WRITE = psum_wr;
   assign DONE       = psum_wr && (o_q == O_LAST);
   assign BUSY       = (state_q != ST_IDLE);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         j_q     <= '0;
         fill_q  <= '0;
         o_q     <= '0;
         for (int i = 0; i < FILT_S; i++) begin
            w_q[i]   <= '0;
            win_q[i] <= '0;
         end
      end else if (EN) begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (START) begin
                  k_q    <= '0;
                  j_q    <= '0;
                  fill_q <= '0;
                  o_q    <= '0;
               end
            end
            ST_LD_F: begin
               if (filt_rd) begin
                  w_q[k_q] <= FILT_DI;
                  k_q      <= k_q + 1'b1;
               end
            end
            ST_LD_I: begin
               if (if_rd) begin
                  for (int i = 0; i < FILT_S - 1; i++) win_q[i] <= win_q[i+1];
                  win_q[FILT_S-1] <= IF_DI;
                  fill_q          <= fill_q + 1'b1;
               end
            end
            ST_MAC: j_q <= (j_q == K_LAST) ? '0 : j_q + 1'b1;
            ST_OUT: begin
               // Next position reuses FILT_S-1 pixels, so one more pop refills the window.
               if (psum_wr) begin
                  fill_q <= FILL_LAST;
                  o_q    <= o_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   pe_row_conv_mac #(
      .DATA_W (DATA_W),
      .PSUM_W (PSUM_W)
   ) u_mac (
      .CLK   (CLK),
      .RESET (RESET),
      .clr   (j_q == '0),
      .en    (mac_en),
      .a     (w_q[j_q]),
      .b     (win_q[j_q]),
      .acc   (acc)
   );

endmodule
